// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with KMP-derived transitions,
// Mealy/Moore output, overlap control and a saturating match counter.
module seq_detect_param #(
    parameter int              PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b11011,
    parameter bit              OVERLAP = 1'b1,
    parameter bit              MOORE   = 1'b0,
    parameter int              CNT_W   = 8,
    localparam int             STW     = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             din_valid,
    input  logic             din,
    input  logic             count_clr,
    output logic             dout,
    output logic [STW-1:0]   present_state,
    output logic [CNT_W-1:0] match_count
);

    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W must be within 2..16");
    end

    function automatic int border_fn();
        int  b;
        bit  ok;
        b = 0;
        for (int k = 1; k < PAT_W; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (PATTERN[PAT_W-1-j] != PATTERN[k-1-j]) ok = 1'b0;
            end
            if (ok) b = k;
        end
        return b;
    endfunction

    localparam int BRD = border_fn();

    // seq[0] is the oldest bit: the matched prefix followed by the new bit.
    function automatic int next_fn(input int s, input bit b);
        logic [16:0] seq;
        int          res;
        bit          ok;
        seq = '0;
        res = 0;
        for (int i = 0; i < s; i++) seq[i] = PATTERN[PAT_W-1-i];
        seq[s] = b;
        for (int k = 1; k <= s + 1; k++) begin
            if (k <= PAT_W) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (seq[s+1-k+j] != PATTERN[PAT_W-1-j]) ok = 1'b0;
                end
                if (ok) res = k;
            end
        end
        if (res == PAT_W && !MOORE) res = OVERLAP ? BRD : 0;
        return res;
    endfunction

    logic [STW-1:0] nxt0 [PAT_W];
    logic [STW-1:0] nxt1 [PAT_W];

    for (genvar s = 0; s < PAT_W; s++) begin : g_tab
        localparam int N0 = next_fn(s, 1'b0);
        localparam int N1 = next_fn(s, 1'b1);
        assign nxt0[s] = STW'(N0);
        assign nxt1[s] = STW'(N1);
    end

    logic [STW-1:0]   state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dout_q, dout_d;
    logic [STW-1:0]   s_eff;
    logic [STW-1:0]   nxt;
    logic             mealy_hit;
    logic             detect;

    always_comb begin
        s_eff = state_q;
        if (MOORE && state_q == STW'(PAT_W)) begin
            s_eff = OVERLAP ? STW'(BRD) : '0;
        end
        nxt = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (s_eff == STW'(i)) nxt = din ? nxt1[i] : nxt0[i];
        end
        mealy_hit = din_valid && (state_q == STW'(PAT_W - 1))
                    && (din == PATTERN[0]);
        detect  = MOORE ? (din_valid && nxt == STW'(PAT_W)) : mealy_hit;
        state_d = din_valid ? nxt : state_q;
        dout_d  = MOORE ? (state_d == STW'(PAT_W)) : 1'b0;
        count_d = count_q;
        if (detect && count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
        end
        if (count_clr) count_d = '0;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= '0;
            count_q <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    assign dout          = MOORE ? dout_q : mealy_hit;
    assign present_state = state_q;
    assign match_count   = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: five configurations share one stimulus
// stream and are compared every cycle against a history-based model.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic clear, din_valid, din, count_clr;

    logic [4:0] dout_w;
    logic [2:0] st_w [5];
    logic [7:0] cnt_w [4];
    logic [2:0] cnt3;
    logic [4:0] pre_dout;

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    localparam logic [4:0] PAT = 5'b11011;
    localparam bit MOV [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit MMO [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam int MCM [5] = '{255, 255, 255, 255, 7};

    always #5 clk = ~clk;

    seq_detect_param u_dut (
        .clk(clk), .clear(clear), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_w[0]),
        .present_state(st_w[0]), .match_count(cnt_w[0])
    );
    seq_detect_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .clear(clear), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_w[1]),
        .present_state(st_w[1]), .match_count(cnt_w[1])
    );
    seq_detect_param #(.MOORE(1'b1)) u_moo (
        .clk(clk), .clear(clear), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_w[2]),
        .present_state(st_w[2]), .match_count(cnt_w[2])
    );
    seq_detect_param #(.MOORE(1'b1), .OVERLAP(1'b0)) u_mnv (
        .clk(clk), .clear(clear), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_w[3]),
        .present_state(st_w[3]), .match_count(cnt_w[3])
    );
    seq_detect_param #(.CNT_W(3)) u_c3 (
        .clk(clk), .clear(clear), .din_valid(din_valid), .din(din),
        .count_clr(count_clr), .dout(dout_w[4]),
        .present_state(st_w[4]), .match_count(cnt3)
    );

    function automatic int cnt_of(input int i);
        return (i == 4) ? int'(cnt3) : int'(cnt_w[i]);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Longest k<=maxk such that the newest k bits equal the first k pattern bits.
    function automatic int mlen(input logic [63:0] h, input int hl,
                                input int maxk);
        bit ok;
        for (int k = maxk; k >= 1; k--) begin
            if (k <= hl) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (h[k-1-j] != PAT[4-j]) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    logic [63:0] mh [5];
    int          ml [5];
    bit          macc [5];
    int          mcnt [5];
    logic [63:0] nh;
    int          nl;
    bit          det;

    initial begin
        for (int i = 0; i < 5; i++) begin
            mh[i] = '0; ml[i] = 0; macc[i] = 1'b0; mcnt[i] = 0;
        end
    end

    always @(posedge clk or posedge clear) begin
        for (int i = 0; i < 5; i++) begin
            if (clear) begin
                mh[i] = '0; ml[i] = 0; macc[i] = 1'b0; mcnt[i] = 0;
            end else begin
                if (din_valid) begin
                    nh  = {mh[i][62:0], din};
                    nl  = (ml[i] < 64) ? ml[i] + 1 : 64;
                    det = (mlen(nh, nl, 5) == 5);
                    if (det && mcnt[i] < MCM[i]) mcnt[i]++;
                    if (det && !MOV[i]) begin
                        nh = '0; nl = 0;
                    end
                    mh[i]   = nh;
                    ml[i]   = nl;
                    macc[i] = det;
                end
                if (count_clr) mcnt[i] = 0;
            end
        end
    end

    int e_st, e_do;
    always @(negedge clk) begin
        if (run_chk) begin
            for (int i = 0; i < 5; i++) begin
                if (MMO[i]) begin
                    e_st = macc[i] ? 5 : mlen(mh[i], ml[i], 4);
                    e_do = int'(macc[i]);
                end else begin
                    e_st = mlen(mh[i], ml[i], 4);
                    e_do = int'(din_valid &&
                           mlen({mh[i][62:0], din}, ml[i] + 1, 5) == 5);
                end
                chk($sformatf("cyc_state%0d", i), int'(st_w[i]), e_st);
                chk($sformatf("cyc_dout%0d", i), int'(dout_w[i]), e_do);
                chk($sformatf("cyc_cnt%0d", i), cnt_of(i), mcnt[i]);
            end
        end
    end

    task automatic vbit(input bit b, input bit cc = 1'b0);
        din_valid = 1'b1;
        din       = b;
        count_clr = cc;
        #2;
        pre_dout  = dout_w;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        count_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            din = ~din;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rst_pulse();
        #2 clear = 1'b1;
        #1 clear = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [4:0] bits;
    int gap_exp [5] = '{1, 2, 3, 4, 2};

    initial begin
        clear = 1'b1; din_valid = 1'b0; din = 1'b0; count_clr = 1'b0;
        pre_dout = '0;
        #12;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst_state%0d", i), int'(st_w[i]), 0);
            chk($sformatf("rst_cnt%0d", i), cnt_of(i), 0);
            chk($sformatf("rst_dout%0d", i), int'(dout_w[i]), 0);
        end
        clear = 1'b0;
        @(posedge clk);
        #1;
        run_chk = 1'b1;

        vbit(1); vbit(1); vbit(0); vbit(1); vbit(1);
        chk("a5_mealy_dout", int'(pre_dout[0]), 1);
        chk("a5_nov_dout", int'(pre_dout[1]), 1);
        chk("a5_mealy_state", int'(st_w[0]), 2);
        chk("a5_nov_state", int'(st_w[1]), 0);
        chk("a5_moore_state", int'(st_w[2]), 5);
        chk("a5_moore_dout", int'(dout_w[2]), 1);
        idle(3);
        chk("a_moore_hold", int'(dout_w[2]), 1);
        vbit(0);
        chk("a6_moore_state", int'(st_w[2]), 3);
        chk("a6_moore_dout", int'(dout_w[2]), 0);
        vbit(1); vbit(1);
        chk("a8_mealy_dout", int'(pre_dout[0]), 1);
        chk("a8_nov_dout", int'(pre_dout[1]), 0);
        chk("a8_mealy_state", int'(st_w[0]), 2);
        chk("a8_moore_dout", int'(dout_w[2]), 1);
        chk("a_cnt_mealy", cnt_of(0), 2);
        chk("a_cnt_nov", cnt_of(1), 1);
        chk("a_cnt_moore", cnt_of(2), 2);
        chk("a_cnt_moore_nov", cnt_of(3), 1);

        rst_pulse();
        bits = PAT;
        for (int i = 0; i < 5; i++) begin
            vbit(bits[4-i]);
            chk($sformatf("gap_state%0d", i), int'(st_w[0]), gap_exp[i]);
            if (i < 4) begin
                idle(3);
                chk($sformatf("gap_hold%0d", i), int'(st_w[0]), gap_exp[i]);
            end
        end
        chk("gap_dout", int'(pre_dout[0]), 1);
        chk("gap_cnt", cnt_of(0), 1);

        rst_pulse();
        repeat (9) begin
            for (int i = 0; i < 5; i++) vbit(bits[4-i]);
        end
        chk("sat_cnt3", cnt_of(4), 7);
        chk("sat_cnt8", cnt_of(0), 9);
        vbit(0); vbit(1); vbit(1, 1'b1);
        chk("clr_det_dout", int'(pre_dout[0]), 1);
        chk("clr_cnt3", cnt_of(4), 0);
        chk("clr_cnt8", cnt_of(0), 0);

        rst_pulse();
        vbit(1); vbit(1); vbit(0); vbit(1);
        chk("mid_state", int'(st_w[0]), 4);
        #2 clear = 1'b1;
        #1;
        chk("mid_async_state", int'(st_w[0]), 0);
        chk("mid_async_cnt", cnt_of(0), 0);
        clear = 1'b0;
        @(posedge clk);
        #1;
        vbit(1);
        chk("mid_after_dout", int'(pre_dout[0]), 0);
        chk("mid_after_state", int'(st_w[0]), 1);
        chk("mid_after_cnt", cnt_of(0), 0);

        @(posedge clk);
        #1;
        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial pattern detector: generalises the fixed 11011 Mealy detector to any pattern of width 2..16.
- Adds selectable Mealy/Moore output mode, selectable overlapping/non-overlapping detection and a saturating match counter.
- Sits between the debounced button-pulse strobe and the seven-segment driver.
- present_state and match_count feed the display directly.

Parameters:
- PAT_W, 5, pattern length in bits (legal 2..16).
- PATTERN, 5'b11011, target sequence; PATTERN[PAT_W-1] is the first bit expected.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping.
- MOORE, 0, 0 = Mealy output, 1 = Moore output.
- CNT_W, 8, width of match_count.

Ports:
- clk  input  1  single system clock, rising edge.
- clear  input  1  asynchronous, active-high reset.
- din_valid  input  1  one-cycle strobe; din is consumed only when high.
- din  input  1  serial data bit.
- count_clr  input  1  synchronous clear of match_count.
- dout  output  1  detection flag.
- present_state  output  STW  current state; STW = $clog2(PAT_W+1).
- match_count  output  CNT_W  number of detections, saturating.

Behaviour:
- State meaning: state = length of the longest suffix of consumed bits that equals a prefix of PATTERN (KMP semantics). Matching is MSB-first.
- State range: Mealy 0..PAT_W-1; Moore 0..PAT_W, where PAT_W is the accept state.
- State updates only on clk edges with din_valid=1. With din_valid=0, state, dout (Moore) and match_count hold.
- Transition from state s with bit b:
  - If b == PATTERN[PAT_W-1-s], next = s+1.
  - Otherwise, next = the longest border of the prefix of length s extended by b (0 if none).
  - The transition table must be derived from PATTERN at elaboration; hand-coding for the default pattern is not acceptable.
- Mealy mode:
  - dout is combinational: dout = din_valid & (state==PAT_W-1) & (din==PATTERN[0]).
  - On that edge, next = B when OVERLAP=1, or 0 when OVERLAP=0. B is the length of the longest proper border of PATTERN (2 for 11011).
- Moore mode:
  - dout is registered: dout = (state==PAT_W). It asserts the cycle after the completing bit and holds until the next valid bit.
  - From the accept state, the next valid bit is processed as from state B (OVERLAP=1) or state 0 (OVERLAP=0).
- match_count:
  - Increments by 1 on each detection edge (Mealy: completing edge; Moore: entry into PAT_W).
  - Saturates at 2^CNT_W-1 and never wraps.
  - count_clr=1 forces 0 on the next edge and wins over a simultaneous detection.
- Reset: clear=1 immediately forces state=0, match_count=0 and Moore dout=0. Mealy dout is 0 whenever din_valid=0. Any partial match is discarded. First valid bit after release is evaluated from state 0.
- Latency: Mealy detection 0 cycles after the completing bit (same edge); Moore 1 cycle.
- Illegal parameters: PAT_W outside 2..16 must trigger an elaboration-time error.

Test Plan:
- Default (Mealy, overlap, 11011). Valid bits 1,1,0,1,1,0,1,1 -> dout high during the 5th and 8th valid cycles only. present_state after 5th = 2, after 8th = 2. match_count = 2.
- OVERLAP=0, same stream -> dout high on the 5th bit only. present_state after 5th = 0. 8th bit produces no pulse. match_count = 1.
- MOORE=1, OVERLAP=1, same stream -> dout rises the cycle after the 5th bit and holds while din_valid=0. It clears after the 6th valid bit (state 3) and re-asserts after the 8th. match_count = 2.
- Gaps: insert 3 cycles of din_valid=0 with din toggling between every valid bit of 11011 -> exactly one detection. State sequence 1,2,3,4,then match; no change during gaps.
- CNT_W=3 with 9 consecutive 11011 patterns -> match_count saturates at 7. Then count_clr asserted on the same cycle as a detection -> match_count = 0.
- Reset mid-pattern: after 1,1,0,1 (state 4), pulse clear asynchronously between edges -> state = 0 immediately. A following 1 gives state 1 and no detection; match_count = 0.
